board_display_reader: RTL and testbench
=======================================

Name: board_display_reader

Overview:
- Read-side consumer of the board word memory that the life pipeline writes back into.
- Converts VGA pixel coordinates into board word reads and extracts one cell bit per pixel.
- Outputs a fixed-latency alive/in-board pixel stream to the VGA colour mux.
- Reads only on word boundaries, which leaves free memory-port slots, and selects the displayed bank once per frame so the picture never tears.

Parameters:
BOARD_SIZE, 128, board width/height in cells (power of two)
WORD_SIZE, 16, cells per memory word; MSB = leftmost cell
LOG_CELL_PX, 2, each cell drawn as 2^LOG_CELL_PX square pixels
READ_LATENCY, 2, cycles from addr_r_out/rd_en_out to data_r_in valid (1..3)
LOG_MAX_ADDR, 12, memory address width (two banks of BOARD_SIZE*BOARD_SIZE/WORD_SIZE words)

Ports:
clk_in  in  1  pixel clock
rstn_in  in  1  synchronous active-low reset
hcount_in  in  11  current pixel x, new value every cycle
vcount_in  in  10  current pixel y
blank_in  in  1  high outside the active video area
bank_sel_in  in  1  bank holding the latest completed generation
data_r_in  in  WORD_SIZE  memory read data
addr_r_out  out  LOG_MAX_ADDR  memory read address
rd_en_out  out  1  read strobe, one cycle per fetched word
alive_out  out  1  cell bit for the delayed pixel
in_board_out  out  1  delayed pixel lies inside the board area and is not blanked
frame_start_out  out  1  one-cycle pulse aligned to the output of pixel (0,0)

Behaviour:
- Reset (rstn_in low at a clock edge):
  - All outputs go to 0.
  - Pipeline valid bits and the latched bank register are cleared.
  - The word register is cleared.
  - Reset mid-frame discards in-flight reads; the first new fetch happens at the next word boundary after release.
- Geometry:
  - cell_x = hcount_in >> LOG_CELL_PX; cell_y = vcount_in >> LOG_CELL_PX.
  - A pixel is in the board when hcount_in < BOARD_SIZE<<LOG_CELL_PX, vcount_in < BOARD_SIZE<<LOG_CELL_PX, and blank_in = 0.
- Address:
  - addr = bank*(BOARD_SIZE*BOARD_SIZE/WORD_SIZE) + cell_y*(BOARD_SIZE/WORD_SIZE) + cell_x/WORD_SIZE.
  - Truncate to LOG_MAX_ADDR bits; there is no wrap beyond the bank.
- Fetch rule: rd_en_out pulses when an in-board pixel has (cell_x mod WORD_SIZE)==0 and (hcount_in mod 2^LOG_CELL_PX)==0. No other reads are issued.
- Pipeline, with pixel P presented at cycle t:
  - Stage A (t+1): addr_r_out/rd_en_out registered. Bit index = WORD_SIZE-1-(cell_x mod WORD_SIZE), plus in-board and frame flags, carried in a shift pipe.
  - Stage B (t+1+READ_LATENCY): if the delayed rd_en is set, data_r_in is latched into word_q; otherwise word_q holds.
  - Output (t+2+READ_LATENCY): alive_out = word_q[bit index] using the word being latched this cycle (bypass), and in_board_out is asserted.
  - Total latency LAT = READ_LATENCY+2, constant for every pixel.
- When in_board_out = 0, alive_out is forced to 0.
- Bank latch: bank_sel_in is sampled only when hcount_in==0 && vcount_in==0. Changes at any other time take effect next frame.
- frame_start_out: a pulse LAT cycles after coordinate (0,0) is presented.
- Coordinates jumping (e.g. hcount wraps at end of line) are tolerated, because each word fetch is triggered by its own first pixel.

Optional Feature:
CURSOR_OVERLAY_EN:
- When defined:
  - Adds ports cursor_x_in/cursor_y_in [log2(BOARD_SIZE)-1:0] and cursor_out (1 bit).
  - cursor_out is high, with latency LAT, for in-board pixels on the cell's 1-pixel border where cell == (cursor_x_in, cursor_y_in).
  - Cursor inputs are sampled at the same cycle as the pixel.
- When undefined: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
All scenarios use the default parameters, so LAT=4, WORDS_PER_ROW=8, board = 512x512 px.
1. Reset:
   - Hold rstn_in low 5 cycles while hcount/vcount sweep.
   - Required: all outputs 0, no rd_en_out.
   - Release at (0,0): first rd_en_out one cycle later, addr 0.
2. Single cell:
   - Memory bank0 word 0 = 16'h8000, all others 0.
   - Required: alive_out=1 exactly for output pixels x 0..3, y 0..3.
   - Cell at x=15 (word 0 = 16'h0001): alive for x 60..63.
3. Read rate:
   - Sweep one full line.
   - Required: exactly 8 rd_en_out pulses, at hcount 0,64,...,448 (+1 cycle).
   - Addresses for line y=4: 8..15.
   - No reads at hcount >= 512 or during blank.
4. Bank switch:
   - Toggle bank_sel_in to 1 at hcount 100, vcount 200.
   - Required: addresses stay in bank 0 for the rest of the frame.
   - Next frame: first address is 1024.
5. Boundary:
   - Pixel (511,511) in board: read addr 1023 issued at x=448, y=508..511, and in_board_out=1 at LAT 4.
   - Pixel (512,0): in_board_out=0, alive_out=0.
6. Reset mid-line:
   - Pulse rstn_in low at hcount 130 while a read is in flight.
   - Required: no stale word appears on alive_out, and the next read occurs at hcount 192.

Source files
------------

// File: rtl/board_display_reader.sv
// Turns VGA pixel coordinates into board-memory word reads and a fixed-latency alive/in-board stream.
// Optional cursor outline overlay is enabled with `define CURSOR_OVERLAY_EN.
module board_display_reader #(
  parameter int BOARD_SIZE   = 128,
  parameter int WORD_SIZE    = 16,
  parameter int LOG_CELL_PX  = 2,
  parameter int READ_LATENCY = 2,
  parameter int LOG_MAX_ADDR = 12
) (
  input  logic                          clk_in,
  input  logic                          rstn_in,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  input  logic                          blank_in,
  input  logic                          bank_sel_in,
  input  logic [WORD_SIZE-1:0]          data_r_in,
`ifdef CURSOR_OVERLAY_EN
  input  logic [$clog2(BOARD_SIZE)-1:0] cursor_x_in,
  input  logic [$clog2(BOARD_SIZE)-1:0] cursor_y_in,
  output logic                          cursor_out,
`endif
  output logic [LOG_MAX_ADDR-1:0]       addr_r_out,
  output logic                          rd_en_out,
  output logic                          alive_out,
  output logic                          in_board_out,
  output logic                          frame_start_out
);

  localparam int LOG_W    = $clog2(WORD_SIZE);
  localparam int WPR      = BOARD_SIZE / WORD_SIZE;
  localparam int WPB      = BOARD_SIZE * BOARD_SIZE / WORD_SIZE;
  localparam int BOARD_PX = BOARD_SIZE << LOG_CELL_PX;
  localparam int CXW      = 11 - LOG_CELL_PX;
  localparam int CYW      = 10 - LOG_CELL_PX;
  localparam int STAGES   = READ_LATENCY;

  logic [CXW-1:0]          cell_x;
  logic [CYW-1:0]          cell_y;
  logic                    origin, in_board_d, fetch_d, bank_eff;
  logic [LOG_W-1:0]        idx_d;
  logic [LOG_MAX_ADDR-1:0] addr_d;
  logic [WORD_SIZE-1:0]    word_eff;

  logic                        bank_q;
  logic [WORD_SIZE-1:0]        word_q;
  logic [STAGES:0]             rd_pipe_q;
  logic [STAGES:0]             vld_pipe_q;
  logic [STAGES:0]             fs_pipe_q;
  logic [STAGES:0][LOG_W-1:0]  idx_pipe_q;

  assign cell_x     = hcount_in[10:LOG_CELL_PX];
  assign cell_y     = vcount_in[9:LOG_CELL_PX];
  assign origin     = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign in_board_d = (hcount_in < 11'(BOARD_PX)) && (vcount_in < 10'(BOARD_PX)) && !blank_in;
  // One read per word, triggered by the word's own first pixel
  assign fetch_d    = in_board_d && (hcount_in[LOG_W+LOG_CELL_PX-1:0] == '0);
  assign idx_d      = LOG_W'(WORD_SIZE - 1) - cell_x[LOG_W-1:0];
  // The origin pixel already uses the freshly sampled bank so the whole frame is consistent
  assign bank_eff   = origin ? bank_sel_in : bank_q;
  assign addr_d     = LOG_MAX_ADDR'(bank_eff) * LOG_MAX_ADDR'(WPB)
                    + LOG_MAX_ADDR'(cell_y) * LOG_MAX_ADDR'(WPR)
                    + LOG_MAX_ADDR'(cell_x >> LOG_W);
  assign rd_en_out  = rd_pipe_q[0];
  // Bypass so the pixel that triggered the fetch sees its own word
  assign word_eff   = rd_pipe_q[STAGES] ? data_r_in : word_q;

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      bank_q          <= 1'b0;
      word_q          <= '0;
      addr_r_out      <= '0;
      rd_pipe_q       <= '0;
      vld_pipe_q      <= '0;
      fs_pipe_q       <= '0;
      idx_pipe_q      <= '0;
      alive_out       <= 1'b0;
      in_board_out    <= 1'b0;
      frame_start_out <= 1'b0;
    end else begin
      if (origin) bank_q <= bank_sel_in;
      addr_r_out      <= addr_d;
      rd_pipe_q       <= {rd_pipe_q[STAGES-1:0], fetch_d};
      vld_pipe_q      <= {vld_pipe_q[STAGES-1:0], in_board_d};
      fs_pipe_q       <= {fs_pipe_q[STAGES-1:0], origin};
      idx_pipe_q      <= {idx_pipe_q[STAGES-1:0], idx_d};
      if (rd_pipe_q[STAGES]) word_q <= data_r_in;
      alive_out       <= vld_pipe_q[STAGES] & word_eff[idx_pipe_q[STAGES]];
      in_board_out    <= vld_pipe_q[STAGES];
      frame_start_out <= fs_pipe_q[STAGES];
    end
  end

`ifdef CURSOR_OVERLAY_EN
  localparam int LOG_B = $clog2(BOARD_SIZE);
  logic            cur_d, edge_h, edge_v;
  logic [STAGES:0] cur_pipe_q;

  assign edge_h = (hcount_in[LOG_CELL_PX-1:0] == '0) || (hcount_in[LOG_CELL_PX-1:0] == '1);
  assign edge_v = (vcount_in[LOG_CELL_PX-1:0] == '0) || (vcount_in[LOG_CELL_PX-1:0] == '1);
  assign cur_d  = in_board_d && (edge_h || edge_v)
               && (cell_x[LOG_B-1:0] == cursor_x_in) && (cell_y[LOG_B-1:0] == cursor_y_in);

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      cur_pipe_q <= '0;
      cursor_out <= 1'b0;
    end else begin
      cur_pipe_q <= {cur_pipe_q[STAGES-1:0], cur_d};
      cursor_out <= cur_pipe_q[STAGES];
    end
  end
`endif

endmodule

// File: tb/tb_board_display_reader.sv
// Directed bench for board_display_reader with a 2-cycle-latency memory model (LAT = 4).
module tb_board_display_reader;
  logic        clk = 1'b0;
  logic        rstn;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        blank, bank_sel;
  logic [15:0] data_r;
  logic [11:0] addr_r;
  logic        rd_en, alive, in_board, frame_start;
`ifdef CURSOR_OVERLAY_EN
  logic [6:0]  cur_x = 7'd0, cur_y = 7'd0;
  logic        cursor;
`endif

  always #5 clk = ~clk;

  board_display_reader dut (
    .clk_in(clk), .rstn_in(rstn), .hcount_in(hcount), .vcount_in(vcount),
    .blank_in(blank), .bank_sel_in(bank_sel), .data_r_in(data_r),
`ifdef CURSOR_OVERLAY_EN
    .cursor_x_in(cur_x), .cursor_y_in(cur_y), .cursor_out(cursor),
`endif
    .addr_r_out(addr_r), .rd_en_out(rd_en), .alive_out(alive),
    .in_board_out(in_board), .frame_start_out(frame_start));

  // Memory: data valid two cycles after the registered address; junk when no read was issued
  logic [15:0] mem [0:4095];
  logic [11:0] a1, a2;
  logic        r1, r2;
  always @(posedge clk) begin
    a1 <= addr_r; r1 <= rd_en;
    a2 <= a1;     r2 <= r1;
  end
  assign data_r = r2 ? mem[a2] : 16'hA5A5;

  int npass = 0, ntot = 0;
  int sh_h[4], sh_v[4];
  bit sh_b[4], sh_ok[4];

  // Present one pixel; sh_*[0] is the pixel just clocked, sh_*[3] the one now on the outputs
  task automatic pix(input int h, input int v, input bit b);
    hcount = 11'(h); vcount = 10'(v); blank = b;
    @(posedge clk); #1;
    for (int i = 3; i > 0; i--) begin
      sh_h[i] = sh_h[i-1]; sh_v[i] = sh_v[i-1]; sh_b[i] = sh_b[i-1]; sh_ok[i] = sh_ok[i-1];
    end
    sh_h[0] = h; sh_v[0] = v; sh_b[0] = b; sh_ok[0] = rstn;
    if (!rstn) for (int i = 0; i < 4; i++) sh_ok[i] = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; bank_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix(i * 37, i * 3, 1'b0);
      ntot++;
      if ({addr_r, rd_en, alive, in_board, frame_start} !== 16'd0)
        $display("FAIL reset_outputs cyc=%0d got addr=%0d rd=%b alive=%b inb=%b fs=%b want all 0",
                 i, addr_r, rd_en, alive, in_board, frame_start);
      else npass++;
    end
    rstn = 1'b1;
    pix(0, 0, 1'b0);
    ntot++;
    if (rd_en !== 1'b1 || addr_r !== 12'd0)
      $display("FAIL reset_first_read got rd=%b addr=%0d want rd=1 addr=0", rd_en, addr_r);
    else npass++;
  endtask

  task automatic test_single_cell;
    bit ea, eib, efs;
    mem[0] = 16'h8000;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 528; x++) begin
        pix(x, y, 1'b0);
        if (sh_ok[3]) begin
          eib = sh_h[3] < 512 && sh_v[3] < 512 && !sh_b[3];
          ea  = eib && sh_h[3] < 4 && sh_v[3] < 4;
          efs = sh_h[3] == 0 && sh_v[3] == 0;
          ntot++;
          if ({alive, in_board, frame_start} !== {ea, eib, efs})
            $display("FAIL cell_msb px=(%0d,%0d) got a/ib/fs=%b%b%b want %b%b%b",
                     sh_h[3], sh_v[3], alive, in_board, frame_start, ea, eib, efs);
          else npass++;
        end
      end
    mem[0] = 16'h0001;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 528; x++) begin
        pix(x, y, 1'b0);
        if (sh_ok[3]) begin
          eib = sh_h[3] < 512 && sh_v[3] < 512 && !sh_b[3];
          ea  = eib && sh_v[3] < 4 && sh_h[3] >= 60 && sh_h[3] <= 63;
          ntot++;
          if ({alive, in_board} !== {ea, eib})
            $display("FAIL cell_lsb px=(%0d,%0d) got a/ib=%b%b want %b%b",
                     sh_h[3], sh_v[3], alive, in_board, ea, eib);
          else npass++;
        end
      end
    mem[0] = 16'h0000;
  endtask

  task automatic test_read_rate;
    int pulses;
    bit er;
    for (int y = 4; y < 6; y++) begin
      pulses = 0;
      for (int x = 0; x < 800; x++) begin
        pix(x, y, (x >= 640) || (y == 5));
        er = sh_h[0] % 64 == 0 && sh_h[0] < 512 && !sh_b[0];
        if (rd_en === 1'b1) pulses++;
        ntot++;
        if (rd_en !== er) $display("FAIL rate_rd px=(%0d,%0d) got %b want %b", x, y, rd_en, er);
        else npass++;
        if (er && rd_en === 1'b1) begin
          ntot++;
          if (addr_r !== 12'(8 + x / 64))
            $display("FAIL rate_addr x=%0d got %0d want %0d", x, addr_r, 8 + x / 64);
          else npass++;
        end
      end
      ntot++;
      if (pulses != ((y == 4) ? 8 : 0))
        $display("FAIL rate_count y=%0d got %0d want %0d", y, pulses, (y == 4) ? 8 : 0);
      else npass++;
    end
  endtask

  task automatic test_bank_switch;
    bank_sel = 1'b0;
    pix(0, 0, 1'b0);
    bank_sel = 1'b1;
    for (int y = 200; y < 202; y++)
      for (int x = (y == 200) ? 100 : 0; x < 600; x++) begin
        pix(x, y, 1'b0);
        if (rd_en === 1'b1) begin
          ntot++;
          if (addr_r !== 12'((y / 4) * 8 + x / 64))
            $display("FAIL bank_hold px=(%0d,%0d) got %0d want %0d", x, y, addr_r, (y / 4) * 8 + x / 64);
          else npass++;
        end
      end
    pix(0, 0, 1'b0);
    ntot++;
    if (rd_en !== 1'b1 || addr_r !== 12'd1024)
      $display("FAIL bank_new_frame got rd=%b addr=%0d want rd=1 addr=1024", rd_en, addr_r);
    else npass++;
    bank_sel = 1'b0;
    pix(64, 4, 1'b0);
    pix(128, 4, 1'b0);
    ntot++;
    if (rd_en !== 1'b1 || addr_r !== 12'd1034)
      $display("FAIL bank_midframe got rd=%b addr=%0d want rd=1 addr=1034", rd_en, addr_r);
    else npass++;
    pix(0, 0, 1'b0);
    ntot++;
    if (addr_r !== 12'd0) $display("FAIL bank_back got addr=%0d want 0", addr_r);
    else npass++;
  endtask

  task automatic test_boundary;
    bit ea, eib;
    mem[1023] = 16'h0001;
    for (int y = 508; y < 513; y++)
      for (int x = 440; x < 528; x++) begin
        pix(x, (y == 512) ? 0 : y, 1'b0);
        if (x == 448) begin
          ntot++;
          if (rd_en !== 1'b1 || addr_r !== ((y == 512) ? 12'd7 : 12'd1023))
            $display("FAIL bound_addr y=%0d got rd=%b addr=%0d", y, rd_en, addr_r);
          else npass++;
        end
        if (sh_ok[3] && sh_h[3] >= 448) begin
          eib = sh_h[3] < 512 && sh_v[3] < 512;
          ea  = eib && sh_h[3] >= 508 && sh_v[3] >= 508;
          ntot++;
          if ({alive, in_board} !== {ea, eib})
            $display("FAIL bound_px px=(%0d,%0d) got a/ib=%b%b want %b%b",
                     sh_h[3], sh_v[3], alive, in_board, ea, eib);
          else npass++;
        end
      end
    mem[1023] = 16'h0000;
  endtask

  task automatic test_reset_mid;
    bit er, ea, eib, seen;
    seen = 1'b0;
    mem[9] = 16'hFFFF; mem[10] = 16'hFFFF; mem[11] = 16'h8000;
    for (int x = 0; x < 300; x++) begin
      rstn = (x != 130);
      pix(x, 4, 1'b0);
      er = rstn && x % 64 == 0;
      ntot++;
      if (rd_en !== er) $display("FAIL rmid_rd x=%0d got %b want %b", x, rd_en, er);
      else npass++;
      if (x > 130 && rd_en === 1'b1 && !seen) begin
        seen = 1'b1;
        ntot++;
        if (x != 192 || addr_r !== 12'd11)
          $display("FAIL rmid_next_read got x=%0d addr=%0d want x=192 addr=11", x, addr_r);
        else npass++;
      end
      if (sh_ok[3]) begin
        eib = sh_h[3] < 512 && sh_v[3] < 512;
        ea  = eib && sh_v[3] == 4 &&
              ((sh_h[3] >= 64 && sh_h[3] < 128) || (sh_h[3] >= 192 && sh_h[3] < 196));
      end else begin
        eib = 1'b0; ea = 1'b0;
      end
      ntot++;
      if ({alive, in_board, frame_start} !== {ea, eib, 1'b0})
        $display("FAIL rmid_px x=%0d out=(%0d) got a/ib/fs=%b%b%b want %b%b0",
                 x, sh_h[3], alive, in_board, frame_start, ea, eib);
      else npass++;
    end
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) begin sh_h[i] = 0; sh_v[i] = 0; sh_b[i] = 1'b1; sh_ok[i] = 1'b0; end
    hcount = '0; vcount = '0; blank = 1'b0; bank_sel = 1'b0; rstn = 1'b0;
    test_reset;
    test_single_cell;
    test_read_rate;
    test_bank_switch;
    test_boundary;
    test_reset_mid;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
